// File: rtl/uart_frame_receiver.sv
// UART receiver: 2-flop rx sync, mid-bit sampling, parity/stop checks, word held on data_valid until data_ready (new frame dropped -> overrun).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority decisions at mid+1 instead of a single sample at mid.
module uart_frame_receiver #(
  parameter int CLK_PER_BIT = 104,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLK_PER_BIT + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t               state;
  logic                 rx_meta, rx_sync;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q, frm_err_q;
  logic                 bit_val, at_sample, last_stop;

`ifdef UART_RX_MAJORITY_EN
  localparam int OFS = 1;
  logic rx_d1, rx_d2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_sync;
      rx_d2 <= rx_d1;
    end
  end

  assign bit_val = (rx_d2 & rx_d1) | (rx_d2 & rx_sync) | (rx_d1 & rx_sync);
`else
  localparam int OFS = 0;
  assign bit_val = rx_sync;
`endif

  // Only the start bit carries the decision offset; later bits are spaced a full bit from it.
  localparam logic [CW-1:0] START_MID = CW'(CLK_PER_BIT / 2 - 1 + OFS);
  localparam logic [CW-1:0] BIT_END   = CW'(CLK_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  assign at_sample = (state == START) ? (cnt == START_MID) : (cnt == BIT_END);
  assign last_stop = (state == STOP) && at_sample && (bit_cnt == LAST_STOP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt <= at_sample ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt       <= '0;
          bit_cnt   <= '0;
          par_err_q <= 1'b0;
          frm_err_q <= 1'b0;
          if (!rx_sync) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (at_sample) begin
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (at_sample) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_sample) begin
            par_err_q <= (PARITY_MODE == 1) ? (^shreg ^ bit_val) : ~(^shreg ^ bit_val);
            state     <= STOP;
          end
        end
        STOP: begin
          if (at_sample) begin
            if (!bit_val) frm_err_q <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (bit_val) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= BREAK_WAIT;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        BREAK_WAIT: begin
          cnt <= '0;
          if (rx_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register: a completing frame wins over an idle slot or a same-cycle transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data          <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (last_stop) begin
        if (!data_valid || data_ready) begin
          data          <= shreg;
          data_valid    <= 1'b1;
          parity_error  <= par_err_q;
          framing_error <= frm_err_q | ~bit_val;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
